// File: rtl/ps2_lane_decoder.sv
// rtl/ps2_lane_decoder.sv - PS/2 set-2 scan-code decoder producing A/S/D/F lane-press events
//
// Consumes the PS2_Controller byte stream and turns make codes for the four
// play keys into lane-press events buffered in a small show-ahead FIFO.
// Break codes clear the per-lane held flags; typematic repeats are swallowed.
// Extended (E0-prefixed) keys never map to lanes.
//
// Optional feature macro: PS2_LANE_TS_EN
//   defined   -> free-running TS_W-bit tick counter; each event carries the
//                tick of its make byte on evt_time.
//   undefined -> no counter, no timestamp storage, no evt_time port.
//
// Ports:
//   clk          in   1     system clock
//   reset        in   1     synchronous, active-low
//   ps2_byte     in   8     received scan-code byte
//   ps2_byte_en  in   1     1-cycle strobe, ps2_byte valid this cycle
//   evt_valid    out  1     FIFO head holds a press event
//   evt_ready    in   1     consumer accepts head (pop on evt_valid & evt_ready)
//   evt_lane     out  2     lane of head event (0=A, 1=S, 2=D, 3=F)
//   evt_time     out  TS_W  tick of head event's make byte (PS2_LANE_TS_EN only)
//   held         out  4     per-lane key-down flags
//   overflow     out  1     sticky: a press was dropped on a full FIFO

module ps2_lane_decoder #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int TS_W  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      ps2_byte,
  input  logic            ps2_byte_en,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [1:0]      evt_lane,
`ifdef PS2_LANE_TS_EN
  output logic [TS_W-1:0] evt_time,
`endif
  output logic [3:0]      held,
  output logic            overflow
);

  // Reject configurations the pointer arithmetic cannot handle.
  if (DEPTH != (1 << AW) || DEPTH < 2 || DEPTH > 16 || TS_W < 1) begin : g_cfg_check
    $error("ps2_lane_decoder: DEPTH must equal 2**AW within 2..16 and TS_W must be >= 1");
  end

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BRK     = 2'd1;
  localparam logic [1:0] S_EXT     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;

  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [3:0]    held_q, held_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [1:0]    lane_mem_q [DEPTH];

`ifdef PS2_LANE_TS_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] ts_mem_q [DEPTH];
`endif

  // ---------------------------------------------------------------------------
  // Lane code lookup
  // ---------------------------------------------------------------------------
  logic       is_lane;
  logic [1:0] lane_code;

  always_comb begin
    is_lane   = 1'b1;
    lane_code = 2'd0;
    case (ps2_byte)
      8'h1C:   lane_code = 2'd0;
      8'h1B:   lane_code = 2'd1;
      8'h23:   lane_code = 2'd2;
      8'h2B:   lane_code = 2'd3;
      default: is_lane   = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scan-code FSM: advances only on strobed bytes
  // ---------------------------------------------------------------------------
  logic make_hit;
  logic brk_hit;

  always_comb begin
    state_d  = state_q;
    make_hit = 1'b0;
    brk_hit  = 1'b0;
    if (ps2_byte_en) begin
      case (state_q)
        S_IDLE: begin
          if (ps2_byte == CODE_BRK) begin
            state_d = S_BRK;
          end else if (ps2_byte == CODE_EXT) begin
            state_d = S_EXT;
          end else begin
            make_hit = is_lane;
          end
        end
        S_BRK: begin
          brk_hit = is_lane;
          state_d = S_IDLE;
        end
        S_EXT: begin
          // Extended keys are ignored, but an extended break still has a
          // trailing key byte that must not be mistaken for a make.
          state_d = (ps2_byte == CODE_BRK) ? S_EXT_BRK : S_IDLE;
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Held flags and press detection
  // ---------------------------------------------------------------------------
  logic push;

  // A make on an already-held lane is typematic repeat and is not an event.
  assign push = make_hit & ~held_q[lane_code];

  always_comb begin
    held_d = held_q;
    if (make_hit) begin
      held_d[lane_code] = 1'b1;
    end
    if (brk_hit) begin
      held_d[lane_code] = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO control
  // ---------------------------------------------------------------------------
  logic pop;
  logic full;
  logic accept;

  assign pop    = evt_valid & evt_ready;
  assign full   = (cnt_q == FULL_CNT);
  // A same-cycle pop frees the slot the push needs, so a full FIFO still
  // accepts the push in that case.
  assign accept = push & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !accept) begin
      ovf_d = 1'b1;
    end
    cnt_d = cnt_q + (AW+1)'(accept) - (AW+1)'(pop);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      held_q   <= 4'b0000;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is cleared on reset so evt_lane reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        lane_mem_q[i] <= 2'd0;
      end
    end else if (accept) begin
      lane_mem_q[wr_ptr_q] <= lane_code;
    end
  end

`ifdef PS2_LANE_TS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ts_mem_q[i] <= '0;
      end
    end else if (accept) begin
      ts_mem_q[wr_ptr_q] <= ts_q;
    end
  end

  assign evt_time = ts_mem_q[rd_ptr_q];
`endif

  // ---------------------------------------------------------------------------
  // Outputs: head of the show-ahead FIFO, straight from registers
  // ---------------------------------------------------------------------------
  assign evt_valid = (cnt_q != '0);
  assign evt_lane  = lane_mem_q[rd_ptr_q];
  assign held      = held_q;
  assign overflow  = ovf_q;

endmodule
